// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, mode encodings and divider clamp for the SPI master
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } state_t;

    // {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic logic [31:0] half_period(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/spi_master_param_if.sv
// rtl/spi_master_param_if.sv - host handshake and SPI pin bundle for spi_master_param
interface spi_master_param_if #(
    parameter int DW   = 8,
    parameter int NSS  = 4,
    parameter int DIVW = 8
);
    localparam int SSW = (NSS > 1) ? $clog2(NSS) : 1;

    logic            start;
    logic [DW-1:0]   data_tx;
    logic [SSW-1:0]  ss_sel;
    logic            cpol;
    logic            cpha;
    logic            lsb_first;
    logic [DIVW-1:0] div;
    logic            busy;
    logic            done;
    logic [DW-1:0]   data_rx;
    logic            miso;
    logic            mosi;
    logic            sck;
    logic [NSS-1:0]  ssn;

    modport master (
        input  start, data_tx, ss_sel, cpol, cpha, lsb_first, div, miso,
        output busy, done, data_rx, mosi, sck, ssn
    );

    modport slave (
        output start, data_tx, ss_sel, cpol, cpha, lsb_first, div, miso,
        input  busy, done, data_rx, mosi, sck, ssn
    );

endinterface

// File: rtl/spi_clkgen.sv
// rtl/spi_clkgen.sv - half-period counter producing SCK edge strobes with a leading/trailing flag
module spi_clkgen #(
    parameter int DIVW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [DIVW-1:0] half,
    output logic            tick,
    output logic            lead
);
    logic [DIVW-1:0] cnt;
    logic            phase;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    // The first strobe after enable is a leading edge, then they alternate.
    assign tick = en && (cnt == half - 1'b1);
    assign lead = ~phase;

endmodule

// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised SPI master: FSM, shift registers and edge counter
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NSS  = 4,
    parameter int DIVW = 8
) (
    input  logic               clk,
    input  logic               rst,
    spi_master_param_if.master bus
);
    localparam int EW = $clog2(2 * DW) + 1;

    state_t          state_q, state_d;
    logic [1:0]      mode_l;
    logic            lsb_l;
    logic [DIVW-1:0] half_l;
    logic [EW-1:0]   edge_cnt;
    logic [DW-1:0]   tx_sr, rx_sr, data_rx_q;
    logic            mosi_q, sck_q, busy_q, done_q;
    logic [NSS-1:0]  ssn_q;
    logic            tick, lead, cpha_l, last_edge;
    logic            accept, edge_go, finish_go, shift_go, sample_go;

    spi_clkgen #(.DIVW(DIVW)) u_clkgen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != IDLE),
        .half (half_l),
        .tick (tick),
        .lead (lead)
    );

    assign cpha_l    = (mode_l == MODE1) || (mode_l == MODE3);
    assign last_edge = (edge_cnt == EW'(2 * DW - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Done holds off acceptance for one cycle so back-to-back starts keep a gap.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        edge_go   = 1'b0;
        finish_go = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !done_q && (32'(bus.ss_sel) < NSS)) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    edge_go = 1'b1;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (tick) begin
                    edge_go = 1'b1;
                    if (last_edge) state_d = HOLD;
                end
            end
            HOLD: begin
                if (tick) begin
                    finish_go = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign shift_go  = edge_go && (cpha_l ? lead : (!lead && !last_edge));
    assign sample_go = edge_go && (cpha_l ? !lead : lead);

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_l    <= MODE0;
            lsb_l     <= 1'b0;
            half_l    <= DIVW'(1);
            edge_cnt  <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            data_rx_q <= '0;
            mosi_q    <= 1'b0;
            sck_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ssn_q     <= '1;
        end else begin
            done_q <= finish_go;
            if (state_q == IDLE) sck_q <= bus.cpol;
            if (accept) begin
                mode_l   <= {bus.cpol, bus.cpha};
                lsb_l    <= bus.lsb_first;
                half_l   <= DIVW'(half_period(32'(bus.div)));
                edge_cnt <= '0;
                busy_q   <= 1'b1;
                ssn_q    <= ~(NSS'(1) << bus.ss_sel);
                if (!bus.cpha) begin
                    mosi_q <= bus.lsb_first ? bus.data_tx[0] : bus.data_tx[DW-1];
                    tx_sr  <= bus.lsb_first ? (bus.data_tx >> 1) : (bus.data_tx << 1);
                end else begin
                    tx_sr  <= bus.data_tx;
                end
            end
            if (edge_go) begin
                sck_q    <= ~sck_q;
                edge_cnt <= edge_cnt + 1'b1;
            end
            if (shift_go) begin
                mosi_q <= lsb_l ? tx_sr[0] : tx_sr[DW-1];
                tx_sr  <= lsb_l ? (tx_sr >> 1) : (tx_sr << 1);
            end
            if (sample_go) begin
                rx_sr <= lsb_l ? {bus.miso, rx_sr[DW-1:1]} : {rx_sr[DW-2:0], bus.miso};
            end
            if (finish_go) begin
                ssn_q     <= '1;
                busy_q    <= 1'b0;
                data_rx_q <= rx_sr;
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.data_rx = data_rx_q;
    assign bus.mosi    = mosi_q;
    assign bus.sck     = sck_q;
    assign bus.ssn     = ssn_q;

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - directed self-checking bench for spi_master_param
module tb_spi_master_param;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    spi_master_param_if #(.DW(8),  .NSS(3), .DIVW(8)) a ();
    spi_master_param_if #(.DW(16), .NSS(4), .DIVW(8)) b ();

    assign a.miso = a.mosi;
    assign b.miso = b.mosi;

    spi_master_param #(.DW(8),  .NSS(3), .DIVW(8)) dut_a (.clk(clk), .rst(rst), .bus(a));
    spi_master_param #(.DW(16), .NSS(4), .DIVW(8)) dut_b (.clk(clk), .rst(rst), .bus(b));

    // Reference slave on ssn[0]: samples mosi on the edge the mode rule selects.
    logic       s_cpol = 1'b0;
    logic       s_cpha = 1'b0;
    logic       sck_prev = 1'b0;
    logic [7:0] slave_rx = 8'h00;
    int         rises = 0;

    always @(negedge clk) begin
        if (a.ssn[0] == 1'b0 && a.sck != sck_prev) begin
            if ((sck_prev == s_cpol) != s_cpha) slave_rx <= {slave_rx[6:0], a.mosi};
            if (a.sck) rises <= rises + 1;
        end
        sck_prev <= a.sck;
    end

    task automatic go(input logic [7:0] d, input logic [1:0] ss, input logic pol,
                      input logic pha, input logic lsb, input logic [7:0] dv);
        @(negedge clk);
        a.data_tx = d; a.ss_sel = ss; a.cpol = pol; a.cpha = pha;
        a.lsb_first = lsb; a.div = dv; a.start = 1'b1;
        s_cpol = pol; s_cpha = pha;
        @(negedge clk);
        a.start = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int limit, output int dcyc,
                             output int lo_first, output int lo_last, output int mosi_hi);
        dcyc = -1; lo_first = -1; lo_last = -1; mosi_hi = 0;
        for (int n = n0; n <= limit; n++) begin
            if (a.ssn != 3'b111) begin
                if (lo_first < 0) lo_first = n;
                lo_last = n;
                if (a.mosi) mosi_hi++;
            end
            if (a.done) begin
                dcyc = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (a.sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b expected 0", a.sck); end
        n_checks++; if (a.mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b expected 0", a.mosi); end
        n_checks++; if (a.ssn !== 3'b111) begin n_fail++; $display("FAIL reset_ssn: got %b expected 111", a.ssn); end
        n_checks++; if (a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", a.busy); end
        n_checks++; if (a.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", a.done); end
        n_checks++; if (a.data_rx !== 8'h00) begin n_fail++; $display("FAIL reset_data_rx: got %h expected 00", a.data_rx); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mode0();
        int r0, dc, f, l, mh;
        r0 = rises;
        go(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 8'd1);
        n_checks++; if (a.busy !== 1'b1) begin n_fail++; $display("FAIL m0_busy_c1: got %b expected 1", a.busy); end
        n_checks++; if (a.ssn !== 3'b110) begin n_fail++; $display("FAIL m0_ssn_c1: got %b expected 110", a.ssn); end
        wait_done(1, 100, dc, f, l, mh);
        n_checks++; if (dc !== 18) begin n_fail++; $display("FAIL m0_done_cycle: got %0d expected 18", dc); end
        n_checks++; if (f !== 1) begin n_fail++; $display("FAIL m0_ssn_first: got %0d expected 1", f); end
        n_checks++; if (l !== 17) begin n_fail++; $display("FAIL m0_ssn_last: got %0d expected 17", l); end
        n_checks++; if (a.data_rx !== 8'hA5) begin n_fail++; $display("FAIL m0_data_rx: got %h expected a5", a.data_rx); end
        n_checks++; if (rises - r0 !== 8) begin n_fail++; $display("FAIL m0_rises: got %0d expected 8", rises - r0); end
        n_checks++; if (slave_rx !== 8'hA5) begin n_fail++; $display("FAIL m0_slave_rx: got %h expected a5", slave_rx); end
        @(negedge clk);
        n_checks++; if ({a.busy, a.done} !== 2'b00) begin n_fail++; $display("FAIL m0_after_done: got %b expected 00", {a.busy, a.done}); end
    endtask

    task automatic test_modes();
        logic [1:0] modes [4];
        int dc, f, l, mh;
        modes = '{MODE0, MODE1, MODE2, MODE3};
        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            a.cpol = modes[m][1]; a.cpha = modes[m][0];
            repeat (2) @(negedge clk);
            n_checks++; if (a.sck !== modes[m][1]) begin n_fail++; $display("FAIL mode%0d_idle_sck: got %b expected %b", m, a.sck, modes[m][1]); end
            go(8'h3C, 2'd0, modes[m][1], modes[m][0], 1'b0, 8'd3);
            wait_done(1, 200, dc, f, l, mh);
            n_checks++; if (dc !== 52) begin n_fail++; $display("FAIL mode%0d_done_cycle: got %0d expected 52", m, dc); end
            n_checks++; if (a.data_rx !== 8'h3C) begin n_fail++; $display("FAIL mode%0d_data_rx: got %h expected 3c", m, a.data_rx); end
            n_checks++; if (slave_rx !== 8'h3C) begin n_fail++; $display("FAIL mode%0d_slave_rx: got %h expected 3c", m, slave_rx); end
            n_checks++; if (a.sck !== modes[m][1]) begin n_fail++; $display("FAIL mode%0d_end_sck: got %b expected %b", m, a.sck, modes[m][1]); end
        end
    endtask

    task automatic test_lsb_first();
        int dc, f, l, mh;
        go(8'h01, 2'd0, 1'b0, 1'b0, 1'b1, 8'd2);
        n_checks++; if (a.mosi !== 1'b1) begin n_fail++; $display("FAIL lsb_first_bit: got %b expected 1", a.mosi); end
        wait_done(1, 200, dc, f, l, mh);
        n_checks++; if (dc !== 35) begin n_fail++; $display("FAIL lsb_done_cycle: got %0d expected 35", dc); end
        n_checks++; if (mh !== 4) begin n_fail++; $display("FAIL lsb_mosi_high_cycles: got %0d expected 4", mh); end
        n_checks++; if (a.data_rx !== 8'h01) begin n_fail++; $display("FAIL lsb_data_rx: got %h expected 01", a.data_rx); end
    endtask

    task automatic test_ignore();
        int dc, f, l, mh, bad;
        go(8'h5A, 2'd0, 1'b0, 1'b0, 1'b0, 8'd1);
        repeat (3) @(negedge clk);
        a.start = 1'b1; a.data_tx = 8'hFF; a.ss_sel = 2'd1; a.div = 8'd5; a.cpha = 1'b1;
        @(negedge clk);
        a.start = 1'b0;
        n_checks++; if (a.ssn !== 3'b110) begin n_fail++; $display("FAIL busy_start_ssn: got %b expected 110", a.ssn); end
        wait_done(5, 100, dc, f, l, mh);
        n_checks++; if (dc !== 18) begin n_fail++; $display("FAIL busy_start_done_cycle: got %0d expected 18", dc); end
        n_checks++; if (a.data_rx !== 8'h5A) begin n_fail++; $display("FAIL busy_start_data_rx: got %h expected 5a", a.data_rx); end
        // start in the done cycle, held into the next one
        a.start = 1'b1; a.data_tx = 8'h96; a.ss_sel = 2'd0; a.cpha = 1'b0; a.div = 8'd1;
        @(negedge clk);
        n_checks++; if (a.busy !== 1'b0) begin n_fail++; $display("FAIL gap_start_at_done: got busy %b expected 0", a.busy); end
        @(negedge clk);
        a.start = 1'b0;
        n_checks++; if (a.busy !== 1'b1) begin n_fail++; $display("FAIL gap_start_after_done: got busy %b expected 1", a.busy); end
        wait_done(1, 100, dc, f, l, mh);
        n_checks++; if (dc !== 18) begin n_fail++; $display("FAIL gap_done_cycle: got %0d expected 18", dc); end
        n_checks++; if (a.data_rx !== 8'h96) begin n_fail++; $display("FAIL gap_data_rx: got %h expected 96", a.data_rx); end
        // ss_sel equal to NSS
        go(8'h11, 2'd3, 1'b0, 1'b0, 1'b0, 8'd1);
        bad = 0;
        for (int n = 0; n < 4; n++) begin
            if (a.busy !== 1'b0 || a.ssn !== 3'b111) bad++;
            @(negedge clk);
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bad_ss_sel: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_reset_mid();
        int dc, f, l, mh;
        go(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 8'd1);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (a.ssn !== 3'b111) begin n_fail++; $display("FAIL rstmid_ssn: got %b expected 111", a.ssn); end
        n_checks++; if (a.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", a.busy); end
        n_checks++; if (a.sck !== 1'b0) begin n_fail++; $display("FAIL rstmid_sck: got %b expected 0", a.sck); end
        n_checks++; if (a.data_rx !== 8'h00) begin n_fail++; $display("FAIL rstmid_data_rx: got %h expected 00", a.data_rx); end
        wait_done(11, 60, dc, f, l, mh);
        n_checks++; if (dc !== -1) begin n_fail++; $display("FAIL rstmid_no_done: got done at %0d expected none", dc); end
        go(8'hC3, 2'd0, 1'b0, 1'b0, 1'b0, 8'd1);
        wait_done(1, 100, dc, f, l, mh);
        n_checks++; if (dc !== 18) begin n_fail++; $display("FAIL rstmid_restart_cycle: got %0d expected 18", dc); end
        n_checks++; if (a.data_rx !== 8'hC3) begin n_fail++; $display("FAIL rstmid_restart_data: got %h expected c3", a.data_rx); end
    endtask

    task automatic test_dw16();
        int dc, others, lo;
        dc = -1; others = 0; lo = 0;
        @(negedge clk);
        b.data_tx = 16'hBEEF; b.ss_sel = 2'd2; b.cpol = 1'b0; b.cpha = 1'b0;
        b.lsb_first = 1'b0; b.div = 8'd2; b.start = 1'b1;
        @(negedge clk);
        b.start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            if (b.ssn[2] == 1'b0) lo++;
            if (b.ssn[1:0] != 2'b11 || b.ssn[3] != 1'b1) others++;
            if (b.done) begin
                dc = n;
                break;
            end
            @(negedge clk);
        end
        n_checks++; if (dc !== 67) begin n_fail++; $display("FAIL dw16_done_cycle: got %0d expected 67", dc); end
        n_checks++; if (b.data_rx !== 16'hBEEF) begin n_fail++; $display("FAIL dw16_data_rx: got %h expected beef", b.data_rx); end
        n_checks++; if (lo !== 66) begin n_fail++; $display("FAIL dw16_ssn2_low_cycles: got %0d expected 66", lo); end
        n_checks++; if (others !== 0) begin n_fail++; $display("FAIL dw16_other_ssn: got %0d cycles expected 0", others); end
    endtask

    initial begin
        a.start = 1'b0; a.data_tx = '0; a.ss_sel = '0; a.cpol = 1'b0;
        a.cpha = 1'b0; a.lsb_first = 1'b0; a.div = 8'd1;
        b.start = 1'b0; b.data_tx = '0; b.ss_sel = '0; b.cpol = 1'b0;
        b.cpha = 1'b0; b.lsb_first = 1'b0; b.div = 8'd1;
        test_reset();
        test_mode0();
        test_modes();
        test_lsb_first();
        test_ignore();
        test_reset_mid();
        test_dw16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached with %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
